// File: rtl/reg_write_arbiter_pkg.sv
// Shared defaults and requester indices for the register-bank write arbiter.
package reg_write_arbiter_pkg;

    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_ADDR_W   = 3;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NREQ     = 3;

    // Requester slots on the arbiter.
    localparam int REQ_CORE = 0;
    localparam int REQ_LSU  = 1;
    localparam int REQ_DBG  = 2;

    // Width of a binary requester index; at least one bit even for a single requester.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first eligible requester at or after rr_ptr wins.
module rr_pick
    import reg_write_arbiter_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int PTR_W = ptr_width(DEF_NREQ)
) (
    input  logic [NREQ-1:0]  eligible,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  gnt_onehot,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             any
);

    // cand_idx[k] is the requester examined k-th in the search order.
    logic [PTR_W-1:0] cand_idx [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            assign cand_idx[gi] = (int'(rr_ptr) + gi >= NREQ)
                                ? PTR_W'(int'(rr_ptr) + gi - NREQ)
                                : PTR_W'(int'(rr_ptr) + gi);
        end
    endgenerate

    // Scan from last to first so the earliest eligible candidate overwrites the rest.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (eligible[cand_idx[k]]) begin
                gnt_idx = cand_idx[k];
                any     = 1'b1;
            end
        end
        gnt_onehot = any ? (NREQ'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the single write port of a load-enabled register bank.
// A grant produces a one-cycle ack plus a one-hot load (or a wp_err pulse when the
// target is protected or out of range); the bank captures on the falling edge.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NREQ     = DEF_NREQ
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REGS-1:0]      wp_mask,
    output logic [NREQ-1:0]          ack,
    output logic [NUM_REGS-1:0]      load,
    output logic [DATA_W-1:0]        wdata,
    output logic                     wp_err,
    output logic [NREQ-1:0]          last_gnt
);

    localparam int PTR_W = ptr_width(NREQ);

    logic [NREQ-1:0]     ack_reg,      ack_next;
    logic [NUM_REGS-1:0] load_reg,     load_next;
    logic [DATA_W-1:0]   wdata_reg,    wdata_next;
    logic                wp_err_reg,   wp_err_next;
    logic [NREQ-1:0]     last_gnt_reg, last_gnt_next;
    logic [PTR_W-1:0]    rr_ptr_reg,   rr_ptr_next;

    logic [NREQ-1:0]     eligible;
    logic [NREQ-1:0]     win_onehot;
    logic [PTR_W-1:0]    win_idx;
    logic                win_any;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic                win_protected;
    logic [NUM_REGS-1:0] load_onehot;

    // A requester acked this cycle is masked so its still-held req cannot double-grant.
    assign eligible = req & ~ack_reg;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .eligible   (eligible),
        .rr_ptr     (rr_ptr_reg),
        .gnt_onehot (win_onehot),
        .gnt_idx    (win_idx),
        .any        (win_any)
    );

    // Select the winner's address and data from the flattened request buses.
    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Out-of-range indices are treated exactly like protected registers.
    always_comb begin
        win_protected = 1'b1;
        if (int'(win_addr) < NUM_REGS) begin
            win_protected = wp_mask[win_addr];
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_load
            assign load_onehot[gi] = (int'(win_addr) == gi);
        end
    endgenerate

    // Grant decode: pulses default low, data bus and pointer hold when idle.
    always_comb begin
        ack_next      = '0;
        load_next     = '0;
        wp_err_next   = 1'b0;
        wdata_next    = wdata_reg;
        last_gnt_next = last_gnt_reg;
        rr_ptr_next   = rr_ptr_reg;
        if (win_any) begin
            ack_next      = win_onehot;
            last_gnt_next = win_onehot;
            wdata_next    = win_data;
            rr_ptr_next   = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + PTR_W'(1);
            if (win_protected) begin
                wp_err_next = 1'b1;
            end else begin
                load_next = load_onehot;
            end
        end
    end

    // State and output registers; reset clears load immediately so a pending bank write is cancelled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_reg      <= '0;
            load_reg     <= '0;
            wdata_reg    <= '0;
            wp_err_reg   <= 1'b0;
            last_gnt_reg <= '0;
            rr_ptr_reg   <= '0;
        end else begin
            ack_reg      <= ack_next;
            load_reg     <= load_next;
            wdata_reg    <= wdata_next;
            wp_err_reg   <= wp_err_next;
            last_gnt_reg <= last_gnt_next;
            rr_ptr_reg   <= rr_ptr_next;
        end
    end

    assign ack      = ack_reg;
    assign load     = load_reg;
    assign wdata    = wdata_reg;
    assign wp_err   = wp_err_reg;
    assign last_gnt = last_gnt_reg;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a falling-edge register bank model.
module tb_reg_write_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  a0, a1, a2;
    logic [15:0] d0, d1, d2;
    logic [8:0]  req_addr;
    logic [47:0] req_data;
    logic [7:0]  wp_mask;
    logic [2:0]  ack;
    logic [7:0]  load;
    logic [15:0] wdata;
    logic        wp_err;
    logic [2:0]  last_gnt;

    logic [15:0] bank [8];
    logic        bank_clear;

    int checks   = 0;
    int failures = 0;

    assign req_addr = {a2, a1, a0};
    assign req_data = {d2, d1, d0};

    reg_write_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .wp_mask  (wp_mask),
        .ack      (ack),
        .load     (load),
        .wdata    (wdata),
        .wp_err   (wp_err),
        .last_gnt (last_gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank: each entry captures wdata on the falling edge while its load bit is high.
    always @(negedge clk) begin
        for (int r = 0; r < 8; r++) begin
            if (bank_clear)   bank[r] <= 16'h1000 + 16'(r);
            else if (load[r]) bank[r] <= wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic after_fall();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; req = '0; wp_mask = '0; bank_clear = 1'b1;
        a0 = '0; a1 = '0; a2 = '0; d0 = '0; d1 = '0; d2 = '0;
        #1 reset = 1'b1;
        #1;
        chk("rst_ack",    ack,      3'b000);
        chk("rst_load",   load,     8'h00);
        chk("rst_wdata",  wdata,    16'h0000);
        chk("rst_wp_err", wp_err,   1'b0);
        chk("rst_lastg",  last_gnt, 3'b000);
        tick();
        tick();
        bank_clear = 1'b0;
        reset = 1'b0;

        // Single write from the core
        req = 3'b001; a0 = 3'd5; d0 = 16'hBEEF;
        tick();
        chk("sw_ack",   ack,      3'b001);
        chk("sw_load",  load,     8'b0010_0000);
        chk("sw_wdata", wdata,    16'hBEEF);
        chk("sw_lastg", last_gnt, 3'b001);
        req = 3'b000;
        after_fall();
        chk("sw_bank5", bank[5], 16'hBEEF);
        tick();
        chk("idle_ack",   ack,      3'b000);
        chk("idle_load",  load,     8'h00);
        chk("idle_wdata", wdata,    16'hBEEF);
        chk("idle_lastg", last_gnt, 3'b001);

        // All three request; pointer sits at 1, then reset lands before the falling edge
        a0 = 3'd1; a1 = 3'd2; a2 = 3'd3;
        d0 = 16'h1111; d1 = 16'h2222; d2 = 16'h3333;
        req = 3'b111;
        tick();
        chk("rot_ack",   ack,      3'b010);
        chk("rot_load",  load,     8'b0000_0100);
        chk("rot_lastg", last_gnt, 3'b010);
        #2 reset = 1'b1;
        #1;
        chk("mrst_ack",    ack,      3'b000);
        chk("mrst_load",   load,     8'h00);
        chk("mrst_wp_err", wp_err,   1'b0);
        chk("mrst_lastg",  last_gnt, 3'b000);
        after_fall();
        chk("mrst_bank2", bank[2], 16'h1002);
        tick();
        reset = 1'b0;

        // Contention after reset: grants 0, 1, 2 in order
        tick();
        chk("ct0_ack",  ack,   3'b001);
        chk("ct0_load", load,  8'b0000_0010);
        chk("ct0_data", wdata, 16'h1111);
        req = 3'b110;
        after_fall();
        chk("ct0_bank1", bank[1], 16'h1111);
        tick();
        chk("ct1_ack",  ack,   3'b010);
        chk("ct1_load", load,  8'b0000_0100);
        chk("ct1_data", wdata, 16'h2222);
        req = 3'b100;
        tick();
        chk("ct2_ack",  ack,   3'b100);
        chk("ct2_load", load,  8'b0000_1000);
        chk("ct2_data", wdata, 16'h3333);
        req = 3'b000;
        after_fall();
        chk("ct2_bank2", bank[2], 16'h2222);
        chk("ct2_bank3", bank[3], 16'h3333);

        // Load unit holds its request: ack every other cycle
        a1 = 3'd4; d1 = 16'h4444; req = 3'b010;
        tick();
        chk("hold_ack0",  ack,  3'b010);
        chk("hold_load0", load, 8'b0001_0000);
        tick();
        chk("hold_ack1",  ack,  3'b000);
        tick();
        chk("hold_ack2",  ack,  3'b010);
        tick();
        chk("hold_ack3",  ack,  3'b000);
        req = 3'b000;
        tick();
        chk("hold_lastg", last_gnt, 3'b010);

        // Debug write to a protected register
        wp_mask = 8'h01; a2 = 3'd0; d2 = 16'hDEAD; req = 3'b100;
        tick();
        chk("wp_ack",   ack,      3'b100);
        chk("wp_err",   wp_err,   1'b1);
        chk("wp_load",  load,     8'h00);
        chk("wp_lastg", last_gnt, 3'b100);
        req = 3'b000;
        after_fall();
        chk("wp_bank0", bank[0], 16'h1000);
        tick();
        chk("wp_err_clr", wp_err, 1'b0);
        chk("wp_ack_clr", ack,    3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the single write path into the CPU's bank of 16-bit load-enabled registers among several requesters: core writeback, load unit, debug port.
- Round-robin arbitration with a registered one-cycle ack.
- Produces a one-hot load vector and a shared write-data bus.
- Each register in the bank captures on the falling clock edge, inside the cycle the arbiter holds load high.

Parameters:
NUM_REGS, 8, number of registers in the bank; width of the load vector.
ADDR_W, 3, register index width; must equal clog2(NUM_REGS).
DATA_W, 16, write-data width.
NREQ, 3, number of requesters; index 0 = core, 1 = load unit, 2 = debug.

Ports:
clk  in  1  system clock; arbiter state updates on rising edge
reset  in  1  asynchronous, active-high reset
req  in  NREQ  per-requester write request; level, held until ack
req_addr  in  NREQ*ADDR_W  flattened target register index; requester i at bits [i*ADDR_W +: ADDR_W]
req_data  in  NREQ*DATA_W  flattened write data; requester i at bits [i*DATA_W +: DATA_W]
wp_mask  in  NUM_REGS  write-protect mask; bit r set = register r must not be loaded
ack  out  NREQ  one-hot, one-cycle grant/completion pulse
load  out  NUM_REGS  one-hot load enable to the register bank
wdata  out  DATA_W  write data to the register bank
wp_err  out  1  one-cycle pulse: the granted write targeted a protected register
last_gnt  out  NREQ  one-hot index of the most recently granted requester; holds its value

Behaviour:
- Reset: all outputs and internal state clear asynchronously while reset is high. ack=0, load=0, wdata=0, wp_err=0, last_gnt=0, rr_ptr=0.
- Eligibility at each rising edge: eligible[i] = req[i] & ~ack[i]. A requester acked in the current cycle is masked, so a req still held at the next edge cannot double-grant.
- Arbitration:
  - Search eligible starting at rr_ptr, wrapping modulo NREQ; the first set bit wins (w).
  - No eligible requester: ack, load and wp_err go to 0; wdata and rr_ptr hold.
- Grant registered on the same edge, all visible for exactly one cycle:
  - ack <= onehot(w)
  - wdata <= req_data[w]
  - last_gnt <= onehot(w)
  - rr_ptr <= (w+1) mod NREQ
- Write-protect check on the granted address (wp_mask sampled at the grant edge):
  - Unprotected (wp_mask[req_addr[w]]=0): load <= onehot(req_addr[w]), wp_err <= 0.
  - Protected: load <= 0, wp_err <= 1. The request is still acked, so the requester does not hang.
- Latency: req asserted before edge N → earliest ack and load during cycle N→N+1. The register captures at the falling edge inside that cycle; its new value is visible from that falling edge.
- Requester rule:
  - Keep req, req_addr and req_data stable until ack is seen high.
  - Drop req in the ack cycle, or present the next write; the next write is eligible one edge later.
  - Peak rate: 1 write/2 cycles per requester; 1 write/cycle aggregate when requesters alternate.
- Fairness: a continuously held req is acked within NREQ cycles of becoming eligible.
- Same-address writes from different requesters are serialized in grant order; the later grant's data persists.
- Invalid address (≥ NUM_REGS, possible only when NUM_REGS < 2**ADDR_W): treat as protected; ack + wp_err, no load.
- Req withdrawn before ack: legal. The requester is simply not granted; no state is retained.
- Reset mid-operation:
  - Reset asserted before the falling edge of a load cycle clears load, so the register is not written.
  - Pending requests are forgotten; rr_ptr returns to 0.
- At most one bit set in each of load and ack, in every cycle.

Decomposition:
- Shared package/header: NUM_REGS, ADDR_W, DATA_W, NREQ defaults; requester index constants REQ_CORE=0, REQ_LSU=1, REQ_DBG=2.
- One natural sub-module: rr_pick, a combinational rotate-priority picker. Inputs: eligible[NREQ], rr_ptr. Outputs: onehot winner, binary winner, any.
- The top module holds all registers: ack, load, wdata, wp_err, last_gnt, rr_ptr.

Test Plan:
- Reset: assert reset mid-cycle with req=3'b111 → ack, load, wp_err, last_gnt read 0 immediately; after release, first grant goes to requester 0.
- Single write: req[0]=1, addr=5, data=16'hBEEF → next cycle ack=3'b001, load=8'b0010_0000, wdata=16'hBEEF; register 5 reads 16'hBEEF after the falling edge.
- Contention: req=3'b111 held with distinct addresses 1/2/3 → acks in order 001, 010, 100 on consecutive cycles; each load one-hot matches its address.
- Held req: req[1] held continuously with no other requests → ack[1] pulses every other cycle, never on back-to-back cycles.
- Write protect: wp_mask=8'h01, req[2] to addr 0 → ack=3'b100, wp_err=1, load=0; register 0 unchanged.
- Reset mid-load: assert reset between the rising edge that set load and the following falling edge → target register keeps its old value.
